io_periph_bank: RTL and testbench

IO_PERIPH_BANK -- requirements
Module: io_periph_bank

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_debounce.sv | 77 +++++++
 rtl/io_periph_bank.sv | 133 +++++++++++++
 tb/tb_io_periph_bank.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared address map and helpers for the memory-mapped I/O peripheral bank.
package io_pkg;

  // Select-bit indices within the CPU data address.
  localparam int unsigned IO_SPACE_BIT   = 8;
  localparam int unsigned IO_LEDS_BIT    = 2;
  localparam int unsigned IO_HEX_BIT     = 3;
  localparam int unsigned IO_KEY_BIT     = 4;
  localparam int unsigned IO_SW_BIT      = 5;
  localparam int unsigned IO_KEY_EVT_BIT = 6;

  // Register offsets, for software-facing documentation and benches.
  localparam logic [31:0] IO_LEDS_ADDR    = 32'h0000_0104;
  localparam logic [31:0] IO_HEX_ADDR     = 32'h0000_0108;
  localparam logic [31:0] IO_KEY_ADDR     = 32'h0000_0110;
  localparam logic [31:0] IO_SW_ADDR      = 32'h0000_0120;
  localparam logic [31:0] IO_KEY_EVT_ADDR = 32'h0000_0140;

  // Expand a 4-bit byte-enable into a 32-bit per-bit enable.
  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{wmask[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit two-flop synchroniser followed by an optional stable-count debouncer.
// Debounce counting is built only when IO_PERIPH_DEBOUNCE_EN is defined;
// otherwise the accepted value is the synchroniser output.
module io_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic sync1_q, sync2_q;
  logic acc_d;

  // Two-flop synchroniser for the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_PERIPH_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            acc_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; accept the new value at the limit.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      acc_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accepted value and debounce counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = acc_q;
`else
  localparam int unsigned UnusedDebounceCycles = DEBOUNCE_CYCLES;

  // Without debounce the accepted value follows the synchroniser directly.
  always_comb begin
    acc_d = sync1_q;
  end

  assign dout = sync2_q;
`endif

  // High in the cycle before dout goes 0->1, so a consumer flop sets on the same edge.
  assign rise = acc_d & ~dout;

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped LED / 7-segment / key / switch peripheral bank.
// Optional feature macro: IO_PERIPH_DEBOUNCE_EN (enables key/switch debounce counters).
module io_periph_bank
  import io_pkg::*;
#(
  parameter int unsigned N_LED           = 10,
  parameter int unsigned N_HEX           = 6,
  parameter int unsigned N_KEY           = 4,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  input  logic                 we,
  output logic [31:0]          rdata,
  input  logic [N_KEY-1:0]     key_n,
  input  logic [N_SW-1:0]      sw,
  output logic [N_LED-1:0]     ledr,
  output logic [4*N_HEX-1:0]   hex_digits
);

  localparam int unsigned HexW = 4 * N_HEX;

  logic [N_KEY-1:0] key_state, key_rise;
  logic [N_SW-1:0]  sw_state, sw_rise;

  logic [N_LED-1:0] ledr_q, ledr_d;
  logic [HexW-1:0]  hex_q, hex_d;
  logic [N_KEY-1:0] key_evt_q, key_evt_d;

  logic        sel_leds, sel_hex, sel_key, sel_sw, sel_evt;
  logic [31:0] wbits;

  // Keys are inverted before synchronising so that 0 means released everywhere.
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_db (
      .clk  (clk),
      .reset(reset),
      .din  (~key_n[i]),
      .dout (key_state[i]),
      .rise (key_rise[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
      .clk  (clk),
      .reset(reset),
      .din  (sw[i]),
      .dout (sw_state[i]),
      .rise (sw_rise[i])
    );
  end

  // Priority-decode the register select into a one-hot set.
  always_comb begin
    sel_leds = 1'b0;
    sel_hex  = 1'b0;
    sel_key  = 1'b0;
    sel_sw   = 1'b0;
    sel_evt  = 1'b0;
    if (addr[IO_SPACE_BIT]) begin
      if (addr[IO_LEDS_BIT])         sel_leds = 1'b1;
      else if (addr[IO_HEX_BIT])     sel_hex  = 1'b1;
      else if (addr[IO_KEY_BIT])     sel_key  = 1'b1;
      else if (addr[IO_SW_BIT])      sel_sw   = 1'b1;
      else if (addr[IO_KEY_EVT_BIT]) sel_evt  = 1'b1;
    end
  end

  assign wbits = byte_mask(wmask);

  // Byte-masked register writes and sticky press events (set beats W1C).
  always_comb begin
    ledr_d    = ledr_q;
    hex_d     = hex_q;
    key_evt_d = key_evt_q;
    if (we && sel_leds) begin
      for (int i = 0; i < N_LED; i++) begin
        ledr_d[i] = wbits[i] ? wdata[i] : ledr_q[i];
      end
    end
    if (we && sel_hex) begin
      for (int i = 0; i < HexW; i++) begin
        hex_d[i] = wbits[i] ? wdata[i] : hex_q[i];
      end
    end
    for (int i = 0; i < N_KEY; i++) begin
      key_evt_d[i] = key_rise[i] |
                     (key_evt_q[i] & ~(we & sel_evt & wdata[i] & wbits[i]));
    end
  end

  // Architectural register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_q    <= '0;
      hex_q     <= '0;
      key_evt_q <= '0;
    end else begin
      ledr_q    <= ledr_d;
      hex_q     <= hex_d;
      key_evt_q <= key_evt_d;
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_leds: rdata = 32'(ledr_q);
      sel_hex:  rdata = 32'(hex_q);
      sel_key:  rdata = 32'(key_state);
      sel_sw:   rdata = 32'(sw_state);
      sel_evt:  rdata = 32'(key_evt_q);
      default:  rdata = '0;
    endcase
  end

  assign ledr       = ledr_q;
  assign hex_digits = hex_q;

  logic unused_in;
  assign unused_in = ^{addr[31:9], addr[7], addr[1:0], wdata, wbits, sw_rise};

endmodule

// File: tb/tb_io_periph_bank.sv
// Directed self-checking bench for io_periph_bank (DEBOUNCE_CYCLES = 4).
// Debounce-specific scenarios are selected with IO_PERIPH_DEBOUNCE_EN.
module tb_io_periph_bank;

  localparam int N_LED = 10;
  localparam int N_HEX = 6;
  localparam int N_KEY = 4;
  localparam int N_SW  = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         addr, wdata, rdata;
  logic [3:0]          wmask;
  logic                we;
  logic [N_KEY-1:0]    key_n;
  logic [N_SW-1:0]     sw;
  logic [N_LED-1:0]    ledr;
  logic [4*N_HEX-1:0]  hex_digits;

  int nvec  = 0;
  int nfail = 0;

  io_periph_bank #(
    .N_LED(N_LED), .N_HEX(N_HEX), .N_KEY(N_KEY), .N_SW(N_SW), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wmask(wmask), .we(we),
    .rdata(rdata), .key_n(key_n), .sw(sw), .ledr(ledr), .hex_digits(hex_digits)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; we = 1'b1;
    step();
    we = 1'b0; addr = '0; wdata = '0; wmask = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; key_n = '1; sw = '0; addr = '0; wdata = '0; wmask = '0; we = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    nvec++; if (ledr !== 10'h000) begin nfail++;
      $display("FAIL reset_ledr got %h expected %h", ledr, 10'h000); end
    nvec++; if (hex_digits !== 24'h000000) begin nfail++;
      $display("FAIL reset_hex got %h expected %h", hex_digits, 24'h0); end
    repeat (6) step();
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL reset_evt got %h expected %h", d, 32'h0); end
    rd(32'h110, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL reset_key got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_leds();
    logic [31:0] d;
    wr(32'h104, 32'hFFFF_FFFF, 4'b0001);
    nvec++; if (ledr !== 10'h0FF) begin nfail++;
      $display("FAIL led_byte0 got %h expected %h", ledr, 10'h0FF); end
    wr(32'h104, 32'hFFFF_FFFF, 4'b0010);
    nvec++; if (ledr !== 10'h3FF) begin nfail++;
      $display("FAIL led_byte1 got %h expected %h", ledr, 10'h3FF); end
    wr(32'h104, 32'h0, 4'b0000);
    nvec++; if (ledr !== 10'h3FF) begin nfail++;
      $display("FAIL led_nomask got %h expected %h", ledr, 10'h3FF); end
    rd(32'h104, d);
    nvec++; if (d !== 32'h3FF) begin nfail++;
      $display("FAIL led_read got %h expected %h", d, 32'h3FF); end
  endtask

  task automatic test_hex();
    logic [31:0] d;
    wr(32'h108, 32'h00AB_CDEF, 4'b1111);
    nvec++; if (hex_digits !== 24'hABCDEF) begin nfail++;
      $display("FAIL hex_write got %h expected %h", hex_digits, 24'hABCDEF); end
    rd(32'h108, d);
    nvec++; if (d !== 32'h00AB_CDEF) begin nfail++;
      $display("FAIL hex_read got %h expected %h", d, 32'h00AB_CDEF); end
    // Byte 3 lies wholly above 4*N_HEX bits and must vanish.
    wr(32'h108, 32'hFFFF_FFFF, 4'b1000);
    rd(32'h108, d);
    nvec++; if (d !== 32'h00AB_CDEF) begin nfail++;
      $display("FAIL hex_high_byte got %h expected %h", d, 32'h00AB_CDEF); end
  endtask

  task automatic test_sw_decode();
    logic [31:0] d;
    sw = 10'h155;
    repeat (10) step();
    rd(32'h120, d);
    nvec++; if (d !== 32'h155) begin nfail++;
      $display("FAIL sw_read got %h expected %h", d, 32'h155); end
    wr(32'h120, 32'h0, 4'b1111);
    rd(32'h120, d);
    nvec++; if (d !== 32'h155) begin nfail++;
      $display("FAIL sw_readonly got %h expected %h", d, 32'h155); end
    rd(32'h0FC, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL non_io_read got %h expected %h", d, 32'h0); end
    wr(32'h004, 32'h0, 4'b1111);
    nvec++; if (ledr !== 10'h3FF) begin nfail++;
      $display("FAIL non_io_write got %h expected %h", ledr, 10'h3FF); end
    rd(32'h10C, d);
    nvec++; if (d !== 32'h3FF) begin nfail++;
      $display("FAIL prio_leds_hex got %h expected %h", d, 32'h3FF); end
    rd(32'h130, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL prio_key_sw got %h expected %h", d, 32'h0); end
  endtask

`ifdef IO_PERIPH_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    int k;
    // Short glitch must be rejected.
    key_n[1] = 1'b0;
    repeat (3) step();
    key_n[1] = 1'b1;
    repeat (8) step();
    rd(32'h110, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL glitch_key got %h expected %h", d, 32'h0); end
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL glitch_evt got %h expected %h", d, 32'h0); end
    // Held press accepted within 2 + 4 cycles.
    key_n[1] = 1'b0;
    k = 0;
    d = '0;
    while (k < 6 && d[1] !== 1'b1) begin
      step();
      k++;
      rd(32'h110, d);
    end
    nvec++; if (d !== 32'h2) begin nfail++;
      $display("FAIL press_key got %h expected %h after %0d cycles", d, 32'h2, k); end
    rd(32'h140, d);
    nvec++; if (d !== 32'h2) begin nfail++;
      $display("FAIL press_evt got %h expected %h", d, 32'h2); end
  endtask

  task automatic test_set_priority();
    logic [31:0] d;
    key_n[1] = 1'b1;
    repeat (8) step();
    wr(32'h140, 32'h2, 4'b0000);
    wr(32'h140, 32'h0, 4'b0001);
    rd(32'h140, d);
    nvec++; if (d !== 32'h2) begin nfail++;
      $display("FAIL w1c_ignored got %h expected %h", d, 32'h2); end
    // Press accepted on the 6th edge; W1C lands on that same edge.
    key_n[1] = 1'b0;
    repeat (5) step();
    wr(32'h140, 32'h2, 4'b0001);
    rd(32'h110, d);
    nvec++; if (d !== 32'h2) begin nfail++;
      $display("FAIL coincide_key got %h expected %h", d, 32'h2); end
    rd(32'h140, d);
    nvec++; if (d !== 32'h2) begin nfail++;
      $display("FAIL coincide_evt got %h expected %h", d, 32'h2); end
    wr(32'h140, 32'h2, 4'b0001);
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL w1c_clear got %h expected %h", d, 32'h0); end
    key_n[1] = 1'b1;
    repeat (8) step();
  endtask
`else
  task automatic test_passthrough();
    logic [31:0] d;
    key_n[0] = 1'b0;
    step();
    key_n[0] = 1'b1;
    rd(32'h110, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL pulse_cycle1 got %h expected %h", d, 32'h0); end
    step();
    rd(32'h110, d);
    nvec++; if (d !== 32'h1) begin nfail++;
      $display("FAIL pulse_cycle2 got %h expected %h", d, 32'h1); end
    rd(32'h140, d);
    nvec++; if (d !== 32'h1) begin nfail++;
      $display("FAIL pulse_evt got %h expected %h", d, 32'h1); end
    step();
    rd(32'h110, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL pulse_cycle3 got %h expected %h", d, 32'h0); end
    wr(32'h140, 32'h1, 4'b0000);
    rd(32'h140, d);
    nvec++; if (d !== 32'h1) begin nfail++;
      $display("FAIL w1c_ignored got %h expected %h", d, 32'h1); end
    // New press event and W1C on the same edge: set must win.
    key_n[0] = 1'b0;
    step();
    key_n[0] = 1'b1;
    wr(32'h140, 32'h1, 4'b0001);
    rd(32'h140, d);
    nvec++; if (d !== 32'h1) begin nfail++;
      $display("FAIL coincide_evt got %h expected %h", d, 32'h1); end
    wr(32'h140, 32'h1, 4'b0001);
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL w1c_clear got %h expected %h", d, 32'h0); end
    repeat (3) step();
  endtask
`endif

  task automatic test_reset_pulse();
    logic [31:0] d;
    key_n[2] = 1'b0;
    repeat (10) step();
    key_n[2] = 1'b1;
    rd(32'h140, d);
    nvec++; if (d !== 32'h4) begin nfail++;
      $display("FAIL evt_before_reset got %h expected %h", d, 32'h4); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    nvec++; if (ledr !== 10'h000) begin nfail++;
      $display("FAIL pulse_ledr got %h expected %h", ledr, 10'h000); end
    nvec++; if (hex_digits !== 24'h000000) begin nfail++;
      $display("FAIL pulse_hex got %h expected %h", hex_digits, 24'h0); end
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL pulse_evt got %h expected %h", d, 32'h0); end
    repeat (8) step();
    rd(32'h140, d);
    nvec++; if (d !== 32'h0) begin nfail++;
      $display("FAIL post_reset_evt got %h expected %h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_hex();
    test_sw_decode();
`ifdef IO_PERIPH_DEBOUNCE_EN
    test_debounce();
    test_set_priority();
`else
    test_passthrough();
`endif
    test_reset_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
